// File: rtl/punc_control_mc_if.sv
// Control bundle between the PUnC multi-cycle controller (master) and the datapath/memory side (slave).
// Carries the instruction/status inputs, every datapath strobe and the debug state.
interface punc_control_mc_if;
  logic [15:0] ir;
  logic        nzp_match;
  logic        mem_ack;

  logic        ir_clr;
  logic        ir_ld;
  logic        pc_clr;
  logic        pc_inc;
  logic        pc_ld;
  logic [1:0]  pc_sel;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_asel;
  logic        rf_wr;
  logic        rf_wsel;
  logic [1:0]  rf_dsel;
  logic        rf_rp_sel;
  logic        temp_ld;
  logic        nzp_ld;
  logic        nzp_clr;
  logic [1:0]  alu_sel;
  logic        alu_a_sel;
  logic        halted;
  logic        mem_fault;
  logic [2:0]  state;

  modport master (
    input  ir, nzp_match, mem_ack,
    output ir_clr, ir_ld, pc_clr, pc_inc, pc_ld, pc_sel,
           mem_req, mem_we, mem_asel,
           rf_wr, rf_wsel, rf_dsel, rf_rp_sel,
           temp_ld, nzp_ld, nzp_clr, alu_sel, alu_a_sel,
           halted, mem_fault, state
  );

  modport slave (
    output ir, nzp_match, mem_ack,
    input  ir_clr, ir_ld, pc_clr, pc_inc, pc_ld, pc_sel,
           mem_req, mem_we, mem_asel,
           rf_wr, rf_wsel, rf_dsel, rf_rp_sel,
           temp_ld, nzp_ld, nzp_clr, alu_sel, alu_a_sel,
           halted, mem_fault, state
  );
endinterface

// File: rtl/punc_control_mc.sv
// PUnC LC3 multi-cycle control FSM: Moore/Mealy strobes per state, memory phases stall until mem_ack.
// 3 cycles per instruction (4 for JSR/LDI/STI) plus one per wait cycle; PUNC_MEM_TIMEOUT_EN adds timeout FAULT.
module punc_control_mc #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  punc_control_mc_if.master  bus
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  typedef struct packed {
    logic       ir_clr;
    logic       ir_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic       pc_ld;
    logic [1:0] pc_sel;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_asel;
    logic       rf_wr;
    logic       rf_wsel;
    logic [1:0] rf_dsel;
    logic       rf_rp_sel;
    logic       temp_ld;
    logic       nzp_ld;
    logic       nzp_clr;
    logic [1:0] alu_sel;
    logic       alu_a_sel;
    logic       halted;
    logic       mem_fault;
  } ctl_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [1:0] ASEL_PC    = 2'd0;
  localparam logic [1:0] ASEL_OFF9  = 2'd1;
  localparam logic [1:0] ASEL_OFF6  = 2'd2;
  localparam logic [1:0] ASEL_RP    = 2'd3;

  localparam logic [1:0] PCSEL_OFF9  = 2'd0;
  localparam logic [1:0] PCSEL_OFF11 = 2'd1;
  localparam logic [1:0] PCSEL_RQ    = 2'd2;

  localparam logic [1:0] DSEL_ALU  = 2'd0;
  localparam logic [1:0] DSEL_MEM  = 2'd1;
  localparam logic [1:0] DSEL_PC   = 2'd2;
  localparam logic [1:0] DSEL_OFF9 = 2'd3;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_AND = 2'd1;
  localparam logic [1:0] ALU_NOT = 2'd2;

  state_e     state_q;
  state_e     state_d;
  state_e     nxt_state;
  ctl_t       ctl;
  logic [3:0] opcode;
  logic       ack;

  assign opcode = bus.ir[15:12];
  assign ack    = bus.mem_ack;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctl       = '0;
    nxt_state = state_q;
    case (state_q)
      S_INIT: begin
        ctl.pc_clr  = 1'b1;
        ctl.ir_clr  = 1'b1;
        ctl.nzp_clr = 1'b1;
        nxt_state   = S_FETCH;
      end

      S_FETCH: begin
        ctl.mem_req  = 1'b1;
        ctl.mem_asel = ASEL_PC;
        ctl.ir_ld    = 1'b1;
        ctl.pc_inc   = 1'b1;
        nxt_state    = S_DECODE;
      end

      S_DECODE: begin
        nxt_state = S_EXEC;
      end

      S_EXEC: begin
        nxt_state = S_FETCH;
        case (opcode)
          OP_ADD, OP_AND: begin
            ctl.rf_wr     = 1'b1;
            ctl.nzp_ld    = 1'b1;
            ctl.alu_sel   = (opcode == OP_AND) ? ALU_AND : ALU_ADD;
            ctl.alu_a_sel = bus.ir[5];
          end
          OP_NOT: begin
            ctl.rf_wr   = 1'b1;
            ctl.nzp_ld  = 1'b1;
            ctl.alu_sel = ALU_NOT;
          end
          OP_BR: begin
            ctl.pc_ld  = bus.nzp_match;
            ctl.pc_sel = PCSEL_OFF9;
          end
          OP_JMP: begin
            ctl.pc_ld  = 1'b1;
            ctl.pc_sel = PCSEL_RQ;
          end
          OP_LEA: begin
            ctl.rf_wr   = 1'b1;
            ctl.rf_dsel = DSEL_OFF9;
            ctl.nzp_ld  = 1'b1;
          end
          OP_LD, OP_LDR: begin
            ctl.mem_req  = 1'b1;
            ctl.mem_asel = (opcode == OP_LD) ? ASEL_OFF9 : ASEL_OFF6;
            ctl.rf_wr    = 1'b1;
            ctl.rf_dsel  = DSEL_MEM;
            ctl.nzp_ld   = 1'b1;
          end
          OP_ST, OP_STR: begin
            ctl.mem_req   = 1'b1;
            ctl.mem_we    = 1'b1;
            ctl.mem_asel  = (opcode == OP_ST) ? ASEL_OFF9 : ASEL_OFF6;
            ctl.rf_rp_sel = 1'b1;
          end
          OP_LDI: begin
            // First read fetches the pointer into the destination register without touching NZP
            ctl.mem_req  = 1'b1;
            ctl.mem_asel = ASEL_OFF9;
            ctl.rf_wr    = 1'b1;
            ctl.rf_dsel  = DSEL_MEM;
            nxt_state    = S_EXEC2;
          end
          OP_STI: begin
            ctl.mem_req  = 1'b1;
            ctl.mem_asel = ASEL_OFF9;
            ctl.temp_ld  = 1'b1;
            nxt_state    = S_EXEC2;
          end
          OP_JSR: begin
            ctl.rf_wr   = 1'b1;
            ctl.rf_wsel = 1'b1;
            ctl.rf_dsel = DSEL_PC;
            nxt_state   = S_EXEC2;
          end
          OP_HLT: begin
            nxt_state = S_HALT;
          end
          default: begin
          end
        endcase
      end

      S_EXEC2: begin
        nxt_state = S_FETCH;
        case (opcode)
          OP_JSR: begin
            ctl.pc_ld  = 1'b1;
            ctl.pc_sel = bus.ir[11] ? PCSEL_OFF11 : PCSEL_RQ;
          end
          OP_LDI: begin
            ctl.mem_req   = 1'b1;
            ctl.mem_asel  = ASEL_RP;
            ctl.rf_rp_sel = 1'b1;
            ctl.rf_wr     = 1'b1;
            ctl.rf_dsel   = DSEL_MEM;
            ctl.nzp_ld    = 1'b1;
          end
          OP_STI: begin
            ctl.mem_req   = 1'b1;
            ctl.mem_we    = 1'b1;
            ctl.mem_asel  = ASEL_RP;
            ctl.rf_rp_sel = 1'b1;
          end
          default: begin
          end
        endcase
      end

      S_HALT: begin
        ctl.halted = 1'b1;
      end

`ifdef PUNC_MEM_TIMEOUT_EN
      S_FAULT: begin
        ctl.mem_fault = 1'b1;
      end
`endif

      default: begin
        nxt_state = S_INIT;
      end
    endcase

    // Unacknowledged memory cycle: hold the request steady, suppress every load, stay put
    if (ctl.mem_req && !ack) begin
      ctl.ir_ld   = 1'b0;
      ctl.pc_inc  = 1'b0;
      ctl.rf_wr   = 1'b0;
      ctl.nzp_ld  = 1'b0;
      ctl.temp_ld = 1'b0;
      nxt_state   = state_q;
    end
  end

`ifdef PUNC_MEM_TIMEOUT_EN
  logic [CNT_W-1:0] wait_q;
  logic [CNT_W-1:0] wait_d;
  logic             timeout;

  // wait_q counts completed unacked request cycles, so it reads MEM_TIMEOUT-1 on the last allowed one
  assign timeout = ctl.mem_req && !ack && (wait_q == CNT_W'(MEM_TIMEOUT - 1));
  assign state_d = timeout ? S_FAULT : nxt_state;

  always_comb begin
    wait_d = '0;
    if (ctl.mem_req && !ack && (state_d == state_q)) begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_cfg;

  assign state_d    = nxt_state;
  assign unused_cfg = (MEM_TIMEOUT > 0) ^ (CNT_W > 0);
`endif

  logic unused_ir;
  assign unused_ir = ^{bus.ir[10:6], bus.ir[4:0]};

  assign bus.ir_clr    = ctl.ir_clr;
  assign bus.ir_ld     = ctl.ir_ld;
  assign bus.pc_clr    = ctl.pc_clr;
  assign bus.pc_inc    = ctl.pc_inc;
  assign bus.pc_ld     = ctl.pc_ld;
  assign bus.pc_sel    = ctl.pc_sel;
  assign bus.mem_req   = ctl.mem_req;
  assign bus.mem_we    = ctl.mem_we;
  assign bus.mem_asel  = ctl.mem_asel;
  assign bus.rf_wr     = ctl.rf_wr;
  assign bus.rf_wsel   = ctl.rf_wsel;
  assign bus.rf_dsel   = ctl.rf_dsel;
  assign bus.rf_rp_sel = ctl.rf_rp_sel;
  assign bus.temp_ld   = ctl.temp_ld;
  assign bus.nzp_ld    = ctl.nzp_ld;
  assign bus.nzp_clr   = ctl.nzp_clr;
  assign bus.alu_sel   = ctl.alu_sel;
  assign bus.alu_a_sel = ctl.alu_a_sel;
  assign bus.halted    = ctl.halted;
  assign bus.mem_fault = ctl.mem_fault;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_punc_control_mc.sv
// Bench for punc_control_mc: walks instructions phase by phase with random ack delays and compares
// every output each cycle against a per-instruction phase table derived from the LC3 opcode rules.
module tb_punc_control_mc;

  localparam int P_INIT = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_EXEC2 = 4, P_HALT = 5, P_FAULT = 6;

  localparam logic [3:0] OP_BR = 4'h0, OP_ADD = 4'h1, OP_LD = 4'h2, OP_ST = 4'h3, OP_JSR = 4'h4,
                         OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7, OP_NOT = 4'h9, OP_LDI = 4'hA,
                         OP_STI = 4'hB, OP_JMP = 4'hC, OP_LEA = 4'hE, OP_HLT = 4'hF;

  typedef struct packed {
    logic       ir_clr, ir_ld, pc_clr, pc_inc, pc_ld;
    logic [1:0] pc_sel;
    logic       mem_req, mem_we;
    logic [1:0] mem_asel;
    logic       rf_wr, rf_wsel;
    logic [1:0] rf_dsel;
    logic       rf_rp_sel, temp_ld, nzp_ld, nzp_clr;
    logic [1:0] alu_sel;
    logic       alu_a_sel, halted, mem_fault;
    logic [2:0] state;
  } obs_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  punc_control_mc_if bus ();

  punc_control_mc #(
    .MEM_TIMEOUT (4),
    .CNT_W       (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t get_obs();
    obs_t o;
    o.ir_clr = bus.ir_clr;   o.ir_ld = bus.ir_ld;     o.pc_clr = bus.pc_clr;
    o.pc_inc = bus.pc_inc;   o.pc_ld = bus.pc_ld;     o.pc_sel = bus.pc_sel;
    o.mem_req = bus.mem_req; o.mem_we = bus.mem_we;   o.mem_asel = bus.mem_asel;
    o.rf_wr = bus.rf_wr;     o.rf_wsel = bus.rf_wsel; o.rf_dsel = bus.rf_dsel;
    o.rf_rp_sel = bus.rf_rp_sel; o.temp_ld = bus.temp_ld; o.nzp_ld = bus.nzp_ld;
    o.nzp_clr = bus.nzp_clr; o.alu_sel = bus.alu_sel; o.alu_a_sel = bus.alu_a_sel;
    o.halted = bus.halted;   o.mem_fault = bus.mem_fault; o.state = bus.state;
    return o;
  endfunction

  // Expected strobes for one cycle of a given instruction phase
  function automatic obs_t exp_out(input int ph, input logic [15:0] iv, input logic ack, input logic nzp);
    obs_t e;
    logic [3:0] op;
    e = '0;
    op = iv[15:12];
    e.state = 3'(ph);
    case (ph)
      P_INIT:  begin e.pc_clr = 1'b1; e.ir_clr = 1'b1; e.nzp_clr = 1'b1; end
      P_FETCH: begin e.mem_req = 1'b1; e.ir_ld = ack; e.pc_inc = ack; end
      P_EXEC: case (op)
        OP_ADD, OP_AND: begin
          e.rf_wr = 1'b1; e.nzp_ld = 1'b1;
          e.alu_sel = (op == OP_AND) ? 2'd1 : 2'd0; e.alu_a_sel = iv[5];
        end
        OP_NOT: begin e.rf_wr = 1'b1; e.nzp_ld = 1'b1; e.alu_sel = 2'd2; end
        OP_BR:  e.pc_ld = nzp;
        OP_JMP: begin e.pc_ld = 1'b1; e.pc_sel = 2'd2; end
        OP_LEA: begin e.rf_wr = 1'b1; e.rf_dsel = 2'd3; e.nzp_ld = 1'b1; end
        OP_LD, OP_LDR: begin
          e.mem_req = 1'b1; e.mem_asel = (op == OP_LD) ? 2'd1 : 2'd2;
          e.rf_wr = ack; e.rf_dsel = 2'd1; e.nzp_ld = ack;
        end
        OP_ST, OP_STR: begin
          e.mem_req = 1'b1; e.mem_we = 1'b1; e.rf_rp_sel = 1'b1;
          e.mem_asel = (op == OP_ST) ? 2'd1 : 2'd2;
        end
        OP_LDI: begin e.mem_req = 1'b1; e.mem_asel = 2'd1; e.rf_wr = ack; e.rf_dsel = 2'd1; end
        OP_STI: begin e.mem_req = 1'b1; e.mem_asel = 2'd1; e.temp_ld = ack; end
        OP_JSR: begin e.rf_wr = 1'b1; e.rf_wsel = 1'b1; e.rf_dsel = 2'd2; end
        default: ;
      endcase
      P_EXEC2: case (op)
        OP_JSR: begin e.pc_ld = 1'b1; e.pc_sel = iv[11] ? 2'd1 : 2'd2; end
        OP_LDI: begin
          e.mem_req = 1'b1; e.mem_asel = 2'd3; e.rf_rp_sel = 1'b1;
          e.rf_wr = ack; e.rf_dsel = 2'd1; e.nzp_ld = ack;
        end
        OP_STI: begin e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_asel = 2'd3; e.rf_rp_sel = 1'b1; end
        default: ;
      endcase
      P_HALT:  e.halted = 1'b1;
      P_FAULT: e.mem_fault = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    check("reset", 32'(get_obs()), 32'(exp_out(P_INIT, bus.ir, 1'b0, 1'b0)));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("init", 32'(get_obs()), 32'(exp_out(P_INIT, bus.ir, 1'b0, 1'b0)));
    @(posedge clk); #1;
  endtask

  // One instruction: list its phases, give each memory phase its wait count, check every cycle
  task automatic run_instr(input logic [15:0] iv, input int w_fetch, input int w_exec, input int w_exec2,
                           input bit abort2, output int n_irld, output int n_rfwr);
    logic [3:0] op;
    int         np;
    int         ph[4];
    bit         memp[4];
    int         wt[4];
    obs_t       o;
    logic       a, z;
    op = iv[15:12];
    ph[0] = P_FETCH; ph[1] = P_DECODE; ph[2] = P_EXEC; ph[3] = P_EXEC2;
    np = (op == OP_JSR || op == OP_LDI || op == OP_STI) ? 4 : 3;
    memp[0] = 1'b1;
    memp[1] = 1'b0;
    memp[2] = op inside {OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI};
    memp[3] = op inside {OP_LDI, OP_STI};
    wt[0] = w_fetch;
    wt[1] = 0;
    wt[2] = memp[2] ? w_exec : 0;
    wt[3] = memp[3] ? w_exec2 : 0;
    n_irld = 0;
    n_rfwr = 0;
    bus.ir = iv;
    for (int i = 0; i < np; i++) begin
      for (int c = 0; c <= wt[i]; c++) begin
        a = memp[i] ? (c == wt[i]) : 1'($urandom_range(0, 1));
        z = 1'($urandom_range(0, 1));
        bus.mem_ack = a;
        bus.nzp_match = z;
        @(negedge clk);
        o = get_obs();
        check($sformatf("op%h_ph%0d_c%0d", op, ph[i], c), 32'(o), 32'(exp_out(ph[i], iv, a, z)));
        if (o.ir_ld) n_irld++;
        if (o.rf_wr) n_rfwr++;
        if (abort2 && ph[i] == P_EXEC2) begin
          rst_n = 1'b0;
          #1;
          check("rst_mid_exec2", 32'(get_obs()), 32'(exp_out(P_INIT, iv, a, z)));
          return;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic hold_halt(input int n);
    logic a, z;
    for (int i = 0; i < n; i++) begin
      a = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      bus.mem_ack = a;
      bus.nzp_match = z;
      @(negedge clk);
      check("halt_hold", 32'(get_obs()), 32'(exp_out(P_HALT, bus.ir, a, z)));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n_irld, n_rfwr;
    logic [15:0] iv;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.ir = 16'h0000;
    bus.mem_ack = 1'b0;
    bus.nzp_match = 1'b0;

    do_reset();

    // ADD R1,R1,#5 with zero-wait memory
    run_instr(16'h1265, 0, 0, 0, 1'b0, n_irld, n_rfwr);
    check("add_rfwr_cnt", 32'(n_rfwr), 32'd1);

    // LD with 3 fetch waits and 2 exec waits: 8 cycles, single ir_ld and rf_wr
    run_instr(16'h2403, 3, 2, 0, 1'b0, n_irld, n_rfwr);
    check("ld_irld_cnt", 32'(n_irld), 32'd1);
    check("ld_rfwr_cnt", 32'(n_rfwr), 32'd1);

    run_instr(16'hB3C2, 0, 0, 0, 1'b0, n_irld, n_rfwr);
    run_instr(16'h4802, 0, 0, 0, 1'b0, n_irld, n_rfwr);
    run_instr(16'h41C0, 0, 0, 0, 1'b0, n_irld, n_rfwr);

    // Ack on the last permitted request cycle of each phase
    run_instr(16'hA5FE, 3, 3, 3, 1'b0, n_irld, n_rfwr);
    check("ldi_rfwr_cnt", 32'(n_rfwr), 32'd2);
    run_instr(16'h0E01, 0, 0, 0, 1'b0, n_irld, n_rfwr);

`ifdef PUNC_MEM_TIMEOUT_EN
    do_reset();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_fetch_wait", 32'(get_obs()), 32'(exp_out(P_FETCH, bus.ir, 1'b0, bus.nzp_match)));
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) begin
      bus.mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("to_fault", 32'(get_obs()), 32'(exp_out(P_FAULT, bus.ir, bus.mem_ack, bus.nzp_match)));
      @(posedge clk); #1;
    end
`else
    do_reset();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("fetch_wait_forever", 32'(get_obs()), 32'(exp_out(P_FETCH, bus.ir, 1'b0, bus.nzp_match)));
      @(posedge clk); #1;
    end
`endif

    do_reset();
    run_instr(16'hF025, 0, 0, 0, 1'b0, n_irld, n_rfwr);
    hold_halt(100);

    do_reset();
    run_instr(16'hA5FE, 0, 0, 2, 1'b1, n_irld, n_rfwr);

    do_reset();
    for (int k = 0; k < 200; k++) begin
      iv = 16'($urandom);
      run_instr(iv, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'b0, n_irld, n_rfwr);
      check("rand_irld_cnt", 32'(n_irld), 32'd1);
      if (iv[15:12] == OP_HLT) begin
        hold_halt(5);
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
